// File: rtl/pipeline_rr_arbiter_pkg.sv
// Shared types and defaults for the pipeline round-robin arbiter.
// Holds the flush-sequencer state enum, default parameter values and
// the width helper used for tags and small counters.
package pipe_arb_pkg;

   localparam int unsigned DEF_N_REQ  = 4;
   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_TAG_W  = 2;
   localparam int unsigned DEF_DEPTH  = 4;

   // FLUSH is only entered from / left to a state differing in both bits
   // or only bit 0, so a decode of FLUSH never glitches.
   typedef enum logic [1:0] {
      RUN   = 2'b00,
      FLUSH = 2'b01,
      DRAIN = 2'b10
   } arb_state_e;

   // Bits needed to index n items (at least 1).
   function automatic int unsigned tag_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pipeline_rr_arbiter_if.sv
// Requester/pipeline bundle of the round-robin arbiter.
// slave : arbiter side (takes requests, drives pipeline stage 0)
// master: environment side (requesters and pipeline stage 0)
// Signals: req_valid/req_data/req_ready (requesters), flush_req/
// flush_busy/flush_done (flush control), pipe_data/pipe_tag/pipe_valid/
// pipe_flush/pipe_stall (pipeline stage 0).
interface pipeline_rr_arbiter_if
   import pipe_arb_pkg::*;
#(
   parameter int unsigned N_REQ  = DEF_N_REQ,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned TAG_W  = DEF_TAG_W
);
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ready;
   logic                    flush_req;
   logic                    flush_busy;
   logic                    flush_done;
   logic [DATA_W-1:0]       pipe_data;
   logic [TAG_W-1:0]        pipe_tag;
   logic                    pipe_valid;
   logic                    pipe_flush;
   logic                    pipe_stall;

   modport slave (
      input  req_valid, req_data, flush_req, pipe_stall,
      output req_ready, flush_busy, flush_done,
             pipe_data, pipe_tag, pipe_valid, pipe_flush
   );

   modport master (
      output req_valid, req_data, flush_req, pipe_stall,
      input  req_ready, flush_busy, flush_done,
             pipe_data, pipe_tag, pipe_valid, pipe_flush
   );
endinterface

// File: rtl/pipeline_rr_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set bit of i_req searching
// upward from i_ptr with wrap-around.
// Ports: i_req (request vector), i_ptr (search start, < N_REQ),
// o_grant_c (one-hot), o_idx_c (encoded winner), o_any_c (any request).
module rr_priority_picker #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned TAG_W = 2
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [TAG_W-1:0] i_ptr,
   output logic [N_REQ-1:0] o_grant_c,
   output logic [TAG_W-1:0] o_idx_c,
   output logic             o_any_c
);
   logic [N_REQ-1:0] w_rot;

   // Rotate so that bit 0 corresponds to the requester at i_ptr.
   assign w_rot = N_REQ'({i_req, i_req} >> i_ptr);

   always_comb begin : pick
      int unsigned w_pos;
      o_grant_c = '0;
      o_idx_c   = '0;
      o_any_c   = 1'b0;
      w_pos     = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (!o_any_c && w_rot[k]) begin
            w_pos = 32'(i_ptr) + k;
            if (w_pos >= N_REQ) w_pos = w_pos - N_REQ;
            o_any_c   = 1'b1;
            o_idx_c   = TAG_W'(w_pos);
            o_grant_c = N_REQ'(1) << w_pos;
         end
      end
   end
endmodule

// File: rtl/pipeline_rr_arbiter.sv
// Round-robin arbiter sharing pipeline stage 0 among N_REQ requesters,
// with a single registered output slot, source tagging, stall handling
// and a flush sequencer (FLUSH for one cycle, then DRAIN for DEPTH cycles).
// Ports: clk, reset (async, active-high), bus (slave side of
// pipeline_rr_arbiter_if carrying requests, pipeline and flush signals).
module pipeline_rr_arbiter
   import pipe_arb_pkg::*;
#(
   parameter int unsigned N_REQ  = DEF_N_REQ,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned TAG_W  = DEF_TAG_W,
   parameter int unsigned DEPTH  = DEF_DEPTH
) (
   input logic                  clk,
   input logic                  reset,
   pipeline_rr_arbiter_if.slave bus
);
   localparam int unsigned      CNT_W    = tag_width(DEPTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
   localparam logic [TAG_W-1:0] TAG_LAST = TAG_W'(N_REQ - 1);

   arb_state_e        r_state;
   arb_state_e        w_next_state;
   logic              r_out_v;
   logic [DATA_W-1:0] r_out_data;
   logic [TAG_W-1:0]  r_out_tag;
   logic [TAG_W-1:0]  r_rr_ptr;
   logic [CNT_W-1:0]  r_drain_cnt;

   logic              w_pipe_valid;
   logic              w_can_load;
   logic              w_last_drain;
   logic              w_pipe_flush;
   logic              w_flush_busy;
   logic              w_flush_done;
   logic              w_any;
   logic              w_grant_v;
   logic [N_REQ-1:0]  w_grant;
   logic [TAG_W-1:0]  w_idx;
   logic [DATA_W-1:0] w_sel_data;

   rr_priority_picker #(
      .N_REQ (N_REQ),
      .TAG_W (TAG_W)
   ) u_picker (
      .i_req     (bus.req_valid),
      .i_ptr     (r_rr_ptr),
      .o_grant_c (w_grant),
      .o_idx_c   (w_idx),
      .o_any_c   (w_any)
   );

   // Slot is only offered downstream in RUN and when stage 0 has room.
   assign w_pipe_valid = r_out_v && !bus.pipe_stall && (r_state == RUN);
   assign w_last_drain = (r_drain_cnt == CNT_LAST);
   // Reset gates the grant so no ready is shown while reset is held.
   assign w_grant_v    = w_can_load && w_any && !reset;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= RUN;
      else       r_state <= w_next_state;
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         RUN:     if (bus.flush_req) w_next_state = FLUSH;
         FLUSH:   w_next_state = DRAIN;
         DRAIN: begin
            if (bus.flush_req)      w_next_state = FLUSH;
            else if (w_last_drain)  w_next_state = RUN;
         end
         default: w_next_state = RUN;
      endcase
   end

   // State-decoded outputs; a re-flush in the last DRAIN cycle suppresses done.
   always_comb begin
      w_can_load   = 1'b0;
      w_pipe_flush = 1'b0;
      w_flush_busy = 1'b0;
      w_flush_done = 1'b0;
      unique case (r_state)
         RUN:   w_can_load = !bus.flush_req && (!r_out_v || w_pipe_valid);
         FLUSH: begin
            w_pipe_flush = 1'b1;
            w_flush_busy = 1'b1;
         end
         DRAIN: begin
            w_flush_busy = 1'b1;
            w_flush_done = w_last_drain && !bus.flush_req;
         end
         default: ;
      endcase
   end

   // Payload of the granted requester.
   always_comb begin
      w_sel_data = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (w_grant[k]) w_sel_data = bus.req_data[k*DATA_W +: DATA_W];
      end
   end

   // Output slot, round-robin pointer and drain counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_v     <= 1'b0;
         r_out_data  <= '0;
         r_out_tag   <= '0;
         r_rr_ptr    <= '0;
         r_drain_cnt <= '0;
      end else begin
         if (r_state == FLUSH) begin
            r_out_v    <= 1'b0;
            r_out_data <= '0;
            r_out_tag  <= '0;
         end else if (w_grant_v) begin
            r_out_v    <= 1'b1;
            r_out_data <= w_sel_data;
            r_out_tag  <= w_idx;
            r_rr_ptr   <= (w_idx == TAG_LAST) ? '0 : w_idx + TAG_W'(1);
         end else if (w_pipe_valid) begin
            r_out_v    <= 1'b0;
         end

         if (r_state == FLUSH)
            r_drain_cnt <= '0;
         else if (r_state == DRAIN)
            r_drain_cnt <= w_last_drain ? '0 : r_drain_cnt + CNT_W'(1);
      end
   end

   assign bus.req_ready  = w_grant_v ? w_grant : '0;
   assign bus.pipe_valid = w_pipe_valid;
   assign bus.pipe_data  = r_out_data;
   assign bus.pipe_tag   = r_out_tag;
   assign bus.pipe_flush = w_pipe_flush;
   assign bus.flush_busy = w_flush_busy;
   assign bus.flush_done = w_flush_done;
endmodule

// File: tb/tb_pipeline_rr_arbiter.sv
// Testbench for pipeline_rr_arbiter: vector table, directed multi-cycle
// sequences, then randomized traffic against a behavioural model.
module tb_pipeline_rr_arbiter;
   import pipe_arb_pkg::*;

   localparam int unsigned N     = 4;
   localparam int unsigned DW    = 32;
   localparam int unsigned TW    = 2;
   localparam int unsigned DEPTH = 4;
   localparam int          NV    = 21;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipeline_rr_arbiter_if #(.N_REQ(N), .DATA_W(DW), .TAG_W(TW)) bus ();

   pipeline_rr_arbiter #(
      .N_REQ (N), .DATA_W (DW), .TAG_W (TW), .DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0] rv;
      logic       st;
      logic       fl;
      logic [3:0] rdy;
      logic       pv;
      logic       cd;
      logic [1:0] tag;
      logic       busy;
      logic       pf;
      logic       dn;
   } vec_t;

   vec_t vecs [NV];

   function automatic vec_t mk(input logic [3:0] rv, input logic st, input logic fl,
                               input logic [3:0] rdy, input logic pv, input logic cd,
                               input logic [1:0] tag, input logic busy, input logic pf,
                               input logic dn);
      vec_t v;
      v.rv = rv; v.st = st; v.fl = fl; v.rdy = rdy; v.pv = pv; v.cd = cd;
      v.tag = tag; v.busy = busy; v.pf = pf; v.dn = dn;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      bus.req_valid  = '0;
      bus.req_data   = '0;
      bus.flush_req  = 1'b0;
      bus.pipe_stall = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   // Behavioural model state
   int unsigned      m_ptr;
   int               m_left;   // remaining busy cycles of a flush sequence
   logic [DW-1:0]    q_data[$];
   int               q_tag[$];
   logic [N-1:0]     mv;
   logic [DW-1:0]    md [N];
   int               transfers;

   initial begin
      // ---------- reset state ----------
      bus.req_valid  = 4'hF;
      bus.req_data   = '0;
      bus.flush_req  = 1'b0;
      bus.pipe_stall = 1'b0;
      reset = 1'b1;
      #2;
      chk("rst ready", bus.req_ready, 0);
      chk("rst pipe_valid", bus.pipe_valid, 0);
      chk("rst pipe_flush", bus.pipe_flush, 0);
      chk("rst flush_busy", bus.flush_busy, 0);
      chk("rst flush_done", bus.flush_done, 0);
      chk("rst pipe_data", bus.pipe_data, 0);
      chk("rst pipe_tag", bus.pipe_tag, 0);

      // ---------- single requester ----------
      do_reset();
      bus.req_data[2*DW +: DW] = 32'hA5A50002;
      transfers = 0;
      for (int c = 0; c < 4; c++) begin
         bus.req_valid = (c < 3) ? 4'b0100 : 4'b1111;
         @(negedge clk);
         chk($sformatf("single c%0d ready", c), bus.req_ready, (c < 3) ? 4'b0100 : 4'b1000);
         chk($sformatf("single c%0d pv", c), bus.pipe_valid, (c > 0) ? 1 : 0);
         if (c > 0) begin
            chk($sformatf("single c%0d tag", c), bus.pipe_tag, 2);
            chk($sformatf("single c%0d data", c), bus.pipe_data, 32'hA5A50002);
         end
         if (c < 3) transfers += int'(bus.req_ready[2] & bus.req_valid[2]);
         next_cycle();
      end
      chk("single transfers", transfers, 3);

      // ---------- table: round-robin, stall, flush ----------
      vecs[0]  = mk(4'hF, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 0);
      vecs[1]  = mk(4'hF, 0, 0, 4'b0010, 1, 1, 0, 0, 0, 0);
      vecs[2]  = mk(4'hF, 0, 0, 4'b0100, 1, 1, 1, 0, 0, 0);
      vecs[3]  = mk(4'hF, 0, 0, 4'b1000, 1, 1, 2, 0, 0, 0);
      vecs[4]  = mk(4'hF, 0, 0, 4'b0001, 1, 1, 3, 0, 0, 0);
      vecs[5]  = mk(4'hF, 0, 0, 4'b0010, 1, 1, 0, 0, 0, 0);
      vecs[6]  = mk(4'hF, 1, 0, 4'b0000, 0, 1, 1, 0, 0, 0);
      vecs[7]  = mk(4'hF, 1, 0, 4'b0000, 0, 1, 1, 0, 0, 0);
      vecs[8]  = mk(4'hF, 1, 0, 4'b0000, 0, 1, 1, 0, 0, 0);
      vecs[9]  = mk(4'hF, 0, 0, 4'b0100, 1, 1, 1, 0, 0, 0);
      vecs[10] = mk(4'h0, 0, 0, 4'b0000, 1, 1, 2, 0, 0, 0);
      vecs[11] = mk(4'h0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
      vecs[12] = mk(4'h2, 0, 0, 4'b0010, 0, 0, 0, 0, 0, 0);
      vecs[13] = mk(4'h0, 1, 1, 4'b0000, 0, 1, 1, 0, 0, 0);
      vecs[14] = mk(4'hF, 0, 0, 4'b0000, 0, 0, 0, 1, 1, 0);
      vecs[15] = mk(4'hF, 0, 0, 4'b0000, 0, 0, 0, 1, 0, 0);
      vecs[16] = mk(4'hF, 0, 0, 4'b0000, 0, 0, 0, 1, 0, 0);
      vecs[17] = mk(4'hF, 0, 0, 4'b0000, 0, 0, 0, 1, 0, 0);
      vecs[18] = mk(4'hF, 0, 0, 4'b0000, 0, 0, 0, 1, 0, 1);
      vecs[19] = mk(4'hF, 0, 0, 4'b0100, 0, 0, 0, 0, 0, 0);
      vecs[20] = mk(4'hF, 0, 0, 4'b1000, 1, 1, 2, 0, 0, 0);
      do_reset();
      for (int i = 0; i < int'(N); i++) bus.req_data[i*DW +: DW] = 32'h10 + 32'(i);
      for (int i = 0; i < NV; i++) begin
         bus.req_valid  = vecs[i].rv;
         bus.pipe_stall = vecs[i].st;
         bus.flush_req  = vecs[i].fl;
         @(negedge clk);
         chk($sformatf("vec%0d ready", i), bus.req_ready, vecs[i].rdy);
         chk($sformatf("vec%0d pipe_valid", i), bus.pipe_valid, vecs[i].pv);
         if (vecs[i].cd) begin
            chk($sformatf("vec%0d pipe_tag", i), bus.pipe_tag, vecs[i].tag);
            chk($sformatf("vec%0d pipe_data", i), bus.pipe_data, 32'h10 + 32'(vecs[i].tag));
         end
         chk($sformatf("vec%0d flush_busy", i), bus.flush_busy, vecs[i].busy);
         chk($sformatf("vec%0d pipe_flush", i), bus.pipe_flush, vecs[i].pf);
         chk($sformatf("vec%0d flush_done", i), bus.flush_done, vecs[i].dn);
         next_cycle();
      end

      // ---------- flush re-arm during DRAIN ----------
      do_reset();
      bus.req_valid = 4'hF;
      for (int k = 0; k < 10; k++) begin
         bus.flush_req = (k == 0 || k == 3);
         @(negedge clk);
         chk($sformatf("rearm k%0d pipe_flush", k), bus.pipe_flush, (k == 1 || k == 4) ? 1 : 0);
         chk($sformatf("rearm k%0d flush_busy", k), bus.flush_busy, (k >= 1 && k <= 8) ? 1 : 0);
         chk($sformatf("rearm k%0d flush_done", k), bus.flush_done, (k == 8) ? 1 : 0);
         chk($sformatf("rearm k%0d ready", k), bus.req_ready, (k == 9) ? 4'b0001 : 4'b0000);
         next_cycle();
      end
      bus.flush_req = 1'b0;

      // ---------- async reset mid-DRAIN ----------
      do_reset();
      bus.req_valid = 4'b0010;     // moves rr_ptr to 2
      next_cycle();
      bus.req_valid = 4'b0000;
      bus.flush_req = 1'b1;
      next_cycle();                // FLUSH
      bus.flush_req = 1'b0;
      next_cycle();                // DRAIN
      bus.req_valid = 4'hF;
      #1;
      chk("arst pre busy", bus.flush_busy, 1);
      reset = 1'b1;
      #1;
      chk("arst pipe_valid", bus.pipe_valid, 0);
      chk("arst pipe_flush", bus.pipe_flush, 0);
      chk("arst flush_busy", bus.flush_busy, 0);
      chk("arst ready", bus.req_ready, 0);
      chk("arst flush_done", bus.flush_done, 0);
      @(posedge clk); #2;
      reset = 1'b0;
      @(negedge clk);
      chk("arst post ready", bus.req_ready, 4'b0001);
      chk("arst post busy", bus.flush_busy, 0);
      next_cycle();

      // ---------- randomized traffic vs model ----------
      do_reset();
      m_ptr = 0; m_left = 0; q_data.delete(); q_tag.delete();
      mv = '0;
      for (int i = 0; i < int'(N); i++) md[i] = '0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         logic st, fl, e_busy, e_pf, e_dn, e_pv, can;
         logic [N-1:0] e_rdy;
         int g;
         for (int i = 0; i < int'(N); i++) begin
            if (!mv[i] && $urandom_range(0, 2) == 0) begin
               mv[i] = 1'b1;
               md[i] = $urandom;
            end
            bus.req_data[i*DW +: DW] = md[i];
         end
         st = ($urandom_range(0, 3) == 0);
         fl = ($urandom_range(0, 29) == 0);
         bus.req_valid  = mv;
         bus.pipe_stall = st;
         bus.flush_req  = fl;

         e_busy = (m_left > 0);
         e_pf   = (m_left == int'(DEPTH) + 1);
         e_dn   = (m_left == 1) && !fl;
         e_pv   = !e_busy && (q_data.size() > 0) && !st;
         can    = !e_busy && !fl && (q_data.size() == 0 || e_pv);
         g = -1;
         if (can) begin
            for (int k = 0; k < int'(N); k++) begin
               int j;
               j = (int'(m_ptr) + k) % int'(N);
               if (g < 0 && mv[j]) g = j;
            end
         end
         e_rdy = (g >= 0) ? (N'(1) << g) : '0;

         @(negedge clk);
         chk($sformatf("rnd%0d ready", cyc), bus.req_ready, e_rdy);
         chk($sformatf("rnd%0d pipe_valid", cyc), bus.pipe_valid, e_pv);
         chk($sformatf("rnd%0d pipe_flush", cyc), bus.pipe_flush, e_pf);
         chk($sformatf("rnd%0d flush_busy", cyc), bus.flush_busy, e_busy);
         chk($sformatf("rnd%0d flush_done", cyc), bus.flush_done, e_dn);
         if (e_pv) begin
            chk($sformatf("rnd%0d pipe_data", cyc), bus.pipe_data, q_data[0]);
            chk($sformatf("rnd%0d pipe_tag", cyc), bus.pipe_tag, q_tag[0]);
         end

         // advance model to the next cycle
         if (e_pv) begin
            void'(q_data.pop_front());
            void'(q_tag.pop_front());
         end
         if (m_left == int'(DEPTH) + 1) begin
            q_data.delete(); q_tag.delete();
            m_left--;
         end else if (m_left > 0) begin
            m_left = fl ? int'(DEPTH) + 1 : m_left - 1;
         end else if (fl) begin
            m_left = int'(DEPTH) + 1;
         end
         if (g >= 0) begin
            q_data.push_back(md[g]);
            q_tag.push_back(g);
            m_ptr = (g + 1) % int'(N);
            mv[g] = 1'b0;
         end
         next_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pipeline_rr_arbiter.md
Name: pipeline_rr_arbiter

Overview:
- Shares the input port of one buffered pipeline chain among N_REQ requesters.
- Uses round-robin arbitration with one registered output slot, and tags each transaction with its source ID so results can be routed back.
- Honours pipeline stall backpressure.
- Sequences a pipeline flush: it issues a one-cycle flush and blocks new grants until the flush has propagated through DEPTH stages.

Parameters:
- N_REQ, 4, number of requesters.
- DATA_W, 32, payload width.
- TAG_W, 2, source tag width; must equal ceil(log2(N_REQ)).
- DEPTH, 4, number of pipeline stages the flush must traverse; must be ≥1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester valid.
- req_data  in  N_REQ*DATA_W  per-requester payload; requester i uses bits [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- flush_req  in  1  request a pipeline flush.
- flush_busy  out  1  high while in FLUSH or DRAIN.
- flush_done  out  1  one-cycle pulse when the flush sequence completes.
- pipe_data  out  DATA_W  payload to pipeline stage 0.
- pipe_tag  out  TAG_W  source ID of pipe_data.
- pipe_valid  out  1  valid to pipeline stage 0.
- pipe_flush  out  1  flush to pipeline stage 0.
- pipe_stall  in  1  stall (buffer full) from pipeline stage 0.

Behaviour:
- Clock and reset: clk rising edge; reset asynchronous, active-high.
- State on reset:
  - state=RUN, out_v=0, out_data=0, out_tag=0, rr_ptr=0, drain_cnt=0.
  - All outputs are 0 during reset.
- Output slot:
  - pipe_data=out_data, pipe_tag=out_tag.
  - pipe_valid = out_v & !pipe_stall, so valid is never presented while stage 0 is full.
  - A drain happens when pipe_valid=1.
- Grant condition:
  - can_load = (state==RUN) & !flush_req & (!out_v | pipe_valid).
  - When can_load is true, search for a requester with valid set, starting at rr_ptr and wrapping modulo N_REQ. The first hit g gets req_ready[g]=1.
  - req_ready is combinational and at most one-hot; it is all-zero when !can_load or no requester is valid.
- On a grant at edge t:
  - out_data=req_data[g], out_tag=g, out_v=1, rr_ptr=(g+1) mod N_REQ.
  - Otherwise, if the slot drains, out_v=0.
  - rr_ptr is unchanged when there is no grant.
- Latency and throughput:
  - A request accepted in cycle t gives pipe_valid in cycle t+1 if pipe_stall=0.
  - Sustained throughput is one transfer per cycle with back-to-back grants.
- Requester rules:
  - A requester holds valid and data stable until granted.
  - The arbiter never drops or duplicates an accepted payload.
- State machine (states in the shared package):
  - RUN:
    - A flush_req sampled high moves to FLUSH.
    - No grant occurs in the flush_req cycle; the existing slot may still drain that cycle.
  - FLUSH (1 cycle):
    - pipe_flush=1, decoded directly from state, glitch-free.
    - out_v, out_data and out_tag are cleared at the end of the cycle.
    - drain_cnt=0; next state is DRAIN.
    - pipe_valid=0 and req_ready=0.
  - DRAIN:
    - req_ready=0 and pipe_valid=0; drain_cnt increments each cycle.
    - When drain_cnt==DEPTH-1: flush_done=1 this cycle and next state is RUN.
    - A flush_req in DRAIN returns to FLUSH, the count restarts, and no flush_done is emitted for the aborted sequence.
  - A flush_req in FLUSH is ignored.
- Flush flags:
  - flush_busy = (state==FLUSH) | (state==DRAIN).
  - rr_ptr is preserved across a flush.
- Reset mid-operation: everything returns immediately to reset values. An in-flight slot and any drain count are discarded.
- pipe_stall asserted while out_v=0 has no effect on granting: the slot is empty, so can_load holds.

Decomposition:
- Package pipe_arb_pkg holds:
  - the state enum {RUN, FLUSH, DRAIN};
  - default parameter constants;
  - the tag-width helper function.
- Sub-module rr_priority_picker: purely combinational.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant, encoded index, any_valid.
  - Reused by other arbiters in the design.

Test Plan:
- Single requester: after reset, requester 2 holds valid with data 0xA5A50002 for 3 cycles. Required: req_ready[2]=1 each cycle; pipe_valid in cycles 1–3 with tag 2; 3 transfers; rr_ptr=3 after the grants.
- Round-robin fairness: all four requesters continuously valid with data 0x10+i, no stall. Required: grant order 0,1,2,3,0,1; pipe_tag follows the same order one cycle later; one transfer per cycle.
- Stall: slot full with tag 1 and data 0x11, pipe_stall held high 3 cycles. Required: pipe_valid=0 and req_ready=0 during the stall, pipe_data held at 0x11. On release, pipe_valid=1 for that payload and the next grant occurs in the same cycle; no loss or duplication.
- Flush sequence: DEPTH=4, flush_req pulsed at cycle t with a full slot. Required:
  - pipe_flush=1 only at t+1;
  - out_v=0 from t+2;
  - flush_busy high t+1..t+5;
  - flush_done pulse at t+5;
  - first new grant at t+6.
- Flush re-arm: a second flush_req in the DRAIN cycle at t+3. Required: FLUSH at t+4, no flush_done at t+5, flush_done at t+8.
- Async reset asserted mid-DRAIN, between clock edges. Required: immediately pipe_valid=0, pipe_flush=0, flush_busy=0, req_ready=0. After release, the first grant goes to requester 0 if it is valid.
